// File: rtl/fpadd_sp_arbiter_if.sv
// fpadd_sp_arbiter_if: requester, response and adder-side signals of the shared-adder arbiter.
interface fpadd_sp_arbiter_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0][33:0] req_x;
  logic [NUM_REQ-1:0][33:0] req_y;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [33:0]              rsp_r;
  logic                     add_ce;
  logic [33:0]              add_x;
  logic [33:0]              add_y;
  logic [33:0]              add_r;
  logic [2:0]               occupancy;
  modport master (
    output req_valid, req_x, req_y, rsp_ready, add_r,
    input  req_ready, rsp_valid, rsp_r, add_ce, add_x, add_y, occupancy
  );
  modport slave (
    input  req_valid, req_x, req_y, rsp_ready, add_r,
    output req_ready, rsp_valid, rsp_r, add_ce, add_x, add_y, occupancy
  );
endinterface

// File: rtl/fpadd_sp_arbiter.sv
// fpadd_sp_arbiter: round-robin sharing of one pipelined FloPoCo adder with tag-routed results.
// Define FPADD_SP_ARBITER_STATS_EN to add per-requester issue and stall counters.
module fpadd_sp_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int NUM_STAGES = 2,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input logic               clk,
  input logic               rst_n,
  fpadd_sp_arbiter_if.slave bus
`ifdef FPADD_SP_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ-1:0][31:0] stat_issued,
  output logic [31:0]              stat_stall
`endif
);
  localparam int T = NUM_STAGES - 1;
  if (NUM_STAGES < 1 || NUM_STAGES > 6) begin : g_bad_stages
    $error("fpadd_sp_arbiter: NUM_STAGES must be 1..6");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_req
    $error("fpadd_sp_arbiter: NUM_REQ must be 2..8");
  end
  logic [NUM_STAGES-1:0] vld_q;
  logic [ID_W-1:0]       id_q [NUM_STAGES];
  logic [ID_W-1:0]       rr_q;
  logic [2:0]            occ_q;
  logic [ID_W-1:0]       g;
  logic [ID_W-1:0]       c;
  logic                  hit;
  logic                  ce;
  logic                  issue;
  logic                  retire;
  // Scan from the highest offset down so the last match is the first hit after rr_q.
  always_comb begin
    hit = 1'b0;
    g   = '0;
    c   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      c = ID_W'((int'(rr_q) + k) % NUM_REQ);
      if (bus.req_valid[c]) begin
        hit = 1'b1;
        g   = c;
      end
    end
    ce     = !(vld_q[T] && !bus.rsp_ready[id_q[T]]);
    issue  = ce && hit;
    retire = vld_q[T] && bus.rsp_ready[id_q[T]];
  end
  assign bus.add_ce    = ce;
  assign bus.req_ready = issue ? (NUM_REQ'(1) << g) : '0;
  assign bus.add_x     = issue ? bus.req_x[g] : '0;
  assign bus.add_y     = issue ? bus.req_y[g] : '0;
  assign bus.rsp_valid = vld_q[T] ? (NUM_REQ'(1) << id_q[T]) : '0;
  assign bus.rsp_r     = bus.add_r;
  assign bus.occupancy = occ_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      rr_q  <= '0;
      occ_q <= '0;
    end else if (ce) begin
      vld_q[0] <= issue;
      for (int s = 1; s < NUM_STAGES; s++) vld_q[s] <= vld_q[s-1];
      if (issue) rr_q <= (g == ID_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;
      occ_q <= occ_q + 3'(issue) - 3'(retire);
    end
  end
  // Ids need no reset: they are only observed through a set vld bit.
  always_ff @(posedge clk) begin
    if (ce) begin
      id_q[0] <= g;
      for (int s = 1; s < NUM_STAGES; s++) id_q[s] <= id_q[s-1];
    end
  end
`ifdef FPADD_SP_ARBITER_STATS_EN
  logic [NUM_REQ-1:0][31:0] iss_q;
  logic [31:0]              stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_q   <= '0;
      stall_q <= '0;
    end else begin
      if (issue) iss_q[g] <= iss_q[g] + 32'd1;
      if (!ce) stall_q <= stall_q + 32'd1;
    end
  end
  assign stat_issued = iss_q;
  assign stat_stall  = stall_q;
`endif
endmodule

// File: tb/tb_fpadd_sp_arbiter.sv
// tb_fpadd_sp_arbiter: random and directed stimulus against a queue-based reference model of the shared adder.
module tb_fpadd_sp_arbiter;
  localparam int NR = 4;
  localparam int NS = 2;
  typedef struct {
    int          id;
    logic [33:0] res;
    int          age;
  } op_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fpadd_sp_arbiter_if #(.NUM_REQ(NR)) bus ();
`ifdef FPADD_SP_ARBITER_STATS_EN
  logic [NR-1:0][31:0] stat_issued;
  logic [31:0]         stat_stall;
`endif
  fpadd_sp_arbiter #(.NUM_REQ(NR), .NUM_STAGES(NS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef FPADD_SP_ARBITER_STATS_EN
    ,
    .stat_issued(stat_issued),
    .stat_stall(stat_stall)
`endif
  );
  function automatic logic [33:0] fadd(logic [33:0] a, logic [33:0] b);
    logic [33:0] t;
    logic [7:0]  e;
    logic [24:0] ma, mb, s;
    int          sh;
    if (b[30:23] > a[30:23]) begin
      t = a;
      a = b;
      b = t;
    end
    e  = a[30:23];
    sh = int'(a[30:23]) - int'(b[30:23]);
    ma = {2'b01, a[22:0]};
    mb = (sh > 24) ? 25'd0 : ({2'b01, b[22:0]} >> sh);
    s  = ma + mb;
    if (s[24]) begin
      s = s >> 1;
      e = e + 8'd1;
    end
    return {2'b01, 1'b0, e, s[22:0]};
  endfunction
  logic [33:0] pipe [NS];
  always_ff @(posedge clk) begin
    if (bus.add_ce) begin
      pipe[0] <= fadd(bus.add_x, bus.add_y);
      for (int k = 1; k < NS; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign bus.add_r = pipe[NS-1];
  op_t         q[$];
  int          ptr;
  logic        pend [NR];
  logic [33:0] px [NR];
  logic [33:0] py [NR];
  int          rcv [NR];
  int          issued_cnt [NR];
  int          stall_cnt;
  int          checks = 0;
  int          errs = 0;
  logic [NR-1:0] last_rdy;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [33:0] rnd_op();
    return {2'b01, 1'b0, 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction
  function automatic int total_rcv();
    int s = 0;
    for (int i = 0; i < NR; i++) s += rcv[i];
    return s;
  endfunction
  // mode 0: random new ops and random rsp_ready; 1: every requester always valid; 2: no new ops.
  task automatic step(int mode, logic [NR-1:0] rdy);
    logic          tail, ce;
    int            g;
    logic [NR-1:0] ev, er;
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (!pend[i] && (mode == 1 || (mode == 0 && $urandom_range(0, 2) == 0))) begin
        pend[i] = 1'b1;
        px[i] = rnd_op();
        py[i] = rnd_op();
      end
      bus.req_valid[i] = pend[i];
      bus.req_x[i]     = px[i];
      bus.req_y[i]     = py[i];
      bus.rsp_ready[i] = (mode == 0) ? ($urandom_range(0, 3) != 0) : rdy[i];
    end
    #1;
    tail = q.size() > 0 && q[0].age == NS;
    ce   = !(tail && !bus.rsp_ready[q[0].id]);
    g    = -1;
    if (ce) begin
      for (int k = 0; k < NR; k++) begin
        if (pend[(ptr + k) % NR]) begin
          g = (ptr + k) % NR;
          break;
        end
      end
    end
    ev = '0;
    er = '0;
    if (tail) ev[q[0].id] = 1'b1;
    if (g >= 0) er[g] = 1'b1;
    last_rdy = bus.req_ready;
    check("add_ce", 64'(bus.add_ce), 64'(ce));
    check("req_ready", 64'(bus.req_ready), 64'(er));
    check("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
    check("occupancy", 64'(bus.occupancy), 64'(q.size()));
    if (tail) check("rsp_r", 64'(bus.rsp_r), 64'(q[0].res));
    if (g >= 0) check("add_xy", {30'd0, bus.add_x}, {30'd0, px[g]});
    @(posedge clk);
    if (!ce) stall_cnt++;
    else begin
      if (tail) begin
        rcv[q[0].id]++;
        void'(q.pop_front());
      end
      foreach (q[j]) q[j].age++;
      if (g >= 0) begin
        q.push_back('{g, fadd(px[g], py[g]), 1});
        pend[g] = 1'b0;
        ptr = (g + 1) % NR;
        issued_cnt[g]++;
      end
    end
  endtask
  task automatic model_reset();
    q.delete();
    ptr = 0;
    stall_cnt = 0;
    for (int i = 0; i < NR; i++) issued_cnt[i] = 0;
  endtask
  initial begin
    int r0, r1;
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.rsp_ready = '0;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b0;
      rcv[i] = 0;
    end
    model_reset();
    #1;
    check("rst_ce", 64'(bus.add_ce), 64'd1);
    check("rst_occ", 64'(bus.occupancy), 64'd0);
    check("rst_rsp", 64'(bus.rsp_valid), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    pend[0] = 1'b1;
    px[0] = 34'h13F800000;
    py[0] = 34'h140000000;
    step(2, '1);
    #1 check("t1_occ0", 64'(bus.occupancy), 64'd1);
    step(2, '1);
    #1;
    check("t1_valid", 64'(bus.rsp_valid), 64'd1);
    check("t1_sum", 64'(bus.rsp_r), 64'h140400000);
    check("t1_occ1", 64'(bus.occupancy), 64'd1);
    step(2, '1);
    #1 check("t1_occ2", 64'(bus.occupancy), 64'd0);
    repeat (NS) step(1, '1);
    r0 = total_rcv();
    for (int j = 0; j < 20; j++) begin
      step(1, '1);
      #1 check("full_occ", 64'(bus.occupancy), 64'(NS));
    end
    check("full_results", 64'(total_rcv() - r0), 64'd20);
    repeat (400) step(0, '0);
    repeat (10) step(2, '1);
    repeat (3) step(1, '1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rsp", 64'(bus.rsp_valid), 64'd0);
    check("async_occ", 64'(bus.occupancy), 64'd0);
    check("async_ce", 64'(bus.add_ce), 64'd1);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step(1, '1);
      check("rr_order", 64'(last_rdy), 64'(1 << (j % NR)));
    end
    repeat (34) step(1, '1);
    repeat (10) step(2, '1);
    pend[1] = 1'b1;
    px[1] = rnd_op();
    py[1] = rnd_op();
    step(2, '1);
    step(2, '1);
    pend[0] = 1'b1;
    px[0] = rnd_op();
    py[0] = rnd_op();
    r1 = rcv[1];
    repeat (3) begin
      step(2, 4'b1101);
      #1 check("stall_occ", 64'(bus.occupancy), 64'd1);
    end
    repeat (4) step(2, '1);
    check("stall_once", 64'(rcv[1] - r1), 64'd1);
    check("stall_q_empty", 64'(q.size()), 64'd0);
`ifdef FPADD_SP_ARBITER_STATS_EN
    for (int i = 0; i < NR; i++) check("stat_issued", 64'(stat_issued[i]), 64'(issued_cnt[i]));
    check("stat_stall", 64'(stat_stall), 64'(stall_cnt));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
